// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and the RV32I datapath.
// The controller owns the strobes and mux selects; the datapath supplies decode fields and flags.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [2:0] alu_control;
  logic [2:0] imm_src;
  logic       illegal_instr;

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output pc_write, ir_write, mem_write, reg_write, adr_src, alu_src_a,
           alu_src_b, result_src, alu_control, imm_src, illegal_instr
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  pc_write, ir_write, mem_write, reg_write, adr_src, alu_src_a,
           alu_src_b, result_src, alu_control, imm_src, illegal_instr
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences ALU, register file,
// unified memory and immediate extender, stalling on the memory ready handshake.
module multicycle_controller (
  input  logic                    clk,
  input  logic                    reset_n,
  multicycle_controller_if.master ctrl
);

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, UTYPE
  } state_t;

  state_t state, state_next;
  logic [2:0] funct_alu;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_next;
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    unique case (ctrl.op)
      OP_SW:              ctrl.imm_src = 3'b001;
      OP_BR:              ctrl.imm_src = 3'b010;
      OP_JAL:             ctrl.imm_src = 3'b011;
      OP_LUI, OP_AUIPC:   ctrl.imm_src = 3'b100;
      default:            ctrl.imm_src = 3'b000;
    endcase
  end

  always_comb begin
    unique case (ctrl.funct3)
      3'b000:  funct_alu = (ctrl.op[5] & ctrl.funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_alu = ALU_SLT;
      3'b110:  funct_alu = ALU_OR;
      3'b111:  funct_alu = ALU_AND;
      default: funct_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    state_next          = state;
    ctrl.pc_write       = 1'b0;
    ctrl.ir_write       = 1'b0;
    ctrl.mem_write      = 1'b0;
    ctrl.reg_write      = 1'b0;
    ctrl.adr_src        = 1'b0;
    ctrl.alu_src_a      = 2'b00;
    ctrl.alu_src_b      = 2'b00;
    ctrl.result_src     = 2'b00;
    ctrl.alu_control    = ALU_ADD;
    ctrl.illegal_instr  = 1'b0;
    unique case (state)
      FETCH: begin
        ctrl.alu_src_b  = 2'b10;
        ctrl.result_src = 2'b10;
        ctrl.ir_write   = ctrl.mem_ready;
        ctrl.pc_write   = ctrl.mem_ready;
        if (ctrl.mem_ready) state_next = DECODE;
      end
      DECODE: begin
        ctrl.alu_src_a = 2'b01;
        ctrl.alu_src_b = 2'b01;
        unique case (ctrl.op)
          OP_LW, OP_SW:     state_next = MEMADR;
          OP_R:             state_next = EXECR;
          OP_I:             state_next = EXECI;
          OP_BR:            state_next = BRANCH;
          OP_JAL:           state_next = JAL;
          OP_LUI, OP_AUIPC: state_next = UTYPE;
          default: begin
            state_next         = FETCH;
            ctrl.illegal_instr = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_src_b = 2'b01;
        state_next     = ctrl.op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        ctrl.adr_src = 1'b1;
        if (ctrl.mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        ctrl.result_src = 2'b01;
        ctrl.reg_write  = 1'b1;
        state_next      = FETCH;
      end
      MEMWRITE: begin
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        if (ctrl.mem_ready) state_next = FETCH;
      end
      EXECR: begin
        ctrl.alu_src_a   = 2'b10;
        ctrl.alu_control = funct_alu;
        state_next       = ALUWB;
      end
      EXECI: begin
        ctrl.alu_src_a   = 2'b10;
        ctrl.alu_src_b   = 2'b01;
        ctrl.alu_control = funct_alu;
        state_next       = ALUWB;
      end
      ALUWB: begin
        ctrl.reg_write = 1'b1;
        state_next     = FETCH;
      end
      BRANCH: begin
        ctrl.alu_src_a   = 2'b10;
        ctrl.alu_control = ALU_SUB;
        ctrl.pc_write    = ctrl.zero ^ ctrl.funct3[0];
        state_next       = FETCH;
      end
      JAL: begin
        ctrl.alu_src_a = 2'b01;
        ctrl.alu_src_b = 2'b10;
        ctrl.pc_write  = 1'b1;
        state_next     = ALUWB;
      end
      UTYPE: begin
        ctrl.alu_src_a = ctrl.op[5] ? 2'b11 : 2'b01;
        ctrl.alu_src_b = 2'b01;
        state_next     = ALUWB;
      end
      default: state_next = FETCH;
    endcase

    // The state is already FETCH while reset is held; strobes must stay quiet regardless of mem_ready
    if (!reset_n) begin
      ctrl.pc_write      = 1'b0;
      ctrl.ir_write      = 1'b0;
      ctrl.mem_write     = 1'b0;
      ctrl.reg_write     = 1'b0;
      ctrl.illegal_instr = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: each instruction is expanded into an
// expected per-cycle output trace from the instruction-class rules and replayed with random mem_ready.
module tb_multicycle_controller;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct {
    logic [17:0] vec;
    int          kind;  // 0 fixed, 1 fetch (strobes follow ready, stalls), 2 memory stall
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  logic [2:0] cur_imm;

  always #5 clk = ~clk;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk    (clk),
    .reset_n(reset_n),
    .ctrl   (bus.master)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [17:0] obs();
    return {bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write, bus.adr_src,
            bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.alu_control,
            bus.imm_src, bus.illegal_instr};
  endfunction

  function automatic logic [17:0] pk(logic pc, logic ir, logic mw, logic rw, logic adr,
                                     logic [1:0] sa, logic [1:0] sb, logic [1:0] rs,
                                     logic [2:0] alu, logic [2:0] imm, logic ill);
    return {pc, ir, mw, rw, adr, sa, sb, rs, alu, imm, ill};
  endfunction

  function automatic logic [2:0] imm_of(logic [6:0] op);
    if (op == OP_SW) return 3'b001;
    if (op == OP_BR) return 3'b010;
    if (op == OP_JAL) return 3'b011;
    if (op == OP_LUI || op == OP_AUIPC) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [2:0] alu_of(logic [6:0] op, logic [2:0] f3, logic f7);
    case (f3)
      3'b000:  return (op[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic add(input string tag, input int kind, input logic pc, input logic mw,
                     input logic rw, input logic adr, input logic [1:0] sa,
                     input logic [1:0] sb, input logic [1:0] rs, input logic [2:0] alu,
                     input logic ill);
    exp_t e;
    e.vec  = pk(pc, 1'b0, mw, rw, adr, sa, sb, rs, alu, cur_imm, ill);
    e.kind = kind;
    e.tag  = tag;
    q.push_back(e);
  endtask

  // Build the expected trace for one instruction, then replay it cycle by cycle
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z);
    int i, stalls;
    logic ready;
    logic [17:0] want;
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
    cur_imm = imm_of(op);
    q.delete();
    add("fetch", 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000, 0);
    case (op)
      OP_LW: begin
        add("decode", 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000, 0);
        add("lw_adr", 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 0);
        add("lw_read", 2, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        add("lw_wb", 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 3'b000, 0);
      end
      OP_SW: begin
        add("decode", 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000, 0);
        add("sw_adr", 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 0);
        add("sw_write", 2, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0);
      end
      OP_R, OP_I: begin
        add("decode", 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000, 0);
        add("exec", 0, 0, 0, 0, 0, 2'b10, (op == OP_I) ? 2'b01 : 2'b00, 2'b00,
            alu_of(op, f3, f7), 0);
        add("aluwb", 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
      end
      OP_BR: begin
        add("decode", 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000, 0);
        add("branch", 0, z ^ f3[0], 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b001, 0);
      end
      OP_JAL: begin
        add("decode", 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000, 0);
        add("jal", 0, 1, 0, 0, 0, 2'b01, 2'b10, 2'b00, 3'b000, 0);
        add("aluwb", 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
      end
      OP_LUI, OP_AUIPC: begin
        add("decode", 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000, 0);
        add("utype", 0, 0, 0, 0, 0, (op == OP_LUI) ? 2'b11 : 2'b01, 2'b01, 2'b00,
            3'b000, 0);
        add("aluwb", 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
      end
      default: add("illegal", 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000, 1);
    endcase
    i = 0;
    stalls = 0;
    while (i < q.size()) begin
      if (q[i].kind != 0) ready = (stalls >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
      else                ready = 1'($urandom_range(0, 1));
      bus.mem_ready = ready;
      @(negedge clk);
      want = q[i].vec;
      if (q[i].kind == 1) begin
        want[17] = ready;
        want[16] = ready;
      end
      check_val(q[i].tag, 32'(obs()), 32'(want));
      @(posedge clk);
      #1;
      if (q[i].kind != 0 && !ready) stalls++;
      else begin
        i++;
        stalls = 0;
      end
    end
  endtask

  function automatic logic [17:0] rst_vec(logic [6:0] op);
    return pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000, imm_of(op), 0);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops [12];
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_LUI, OP_AUIPC,
            7'b1111111, 7'b0000000, 7'b1110011, 7'b0001111};
    reset_n = 1'b0;
    bus.op = OP_LW; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
    bus.zero = 1'b0; bus.mem_ready = 1'b1;
    #3;
    check_val("reset_out", 32'(obs()), 32'(rst_vec(OP_LW)));
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_hold", 32'(obs()), 32'(rst_vec(OP_LW)));
    reset_n = 1'b1;

    run_instr(OP_LW, 3'b010, 1'b0, 1'b0);
    run_instr(OP_SW, 3'b010, 1'b0, 1'b0);
    run_instr(OP_R, 3'b000, 1'b1, 1'b0);
    run_instr(OP_R, 3'b010, 1'b0, 1'b0);
    run_instr(OP_I, 3'b000, 1'b1, 1'b0);
    run_instr(OP_BR, 3'b000, 1'b0, 1'b1);
    run_instr(OP_BR, 3'b001, 1'b0, 1'b1);
    run_instr(OP_LUI, 3'b000, 1'b0, 1'b0);
    run_instr(OP_AUIPC, 3'b000, 1'b0, 1'b0);
    run_instr(OP_JAL, 3'b000, 1'b0, 1'b0);
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0);

    // Abort a store in MEMWRITE with an asynchronous reset
    bus.op = OP_SW; bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check_val("abort_mw", 32'(obs()),
              32'(pk(0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0)));
    #1;
    reset_n = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    check_val("abort_rst", 32'(obs()), 32'(rst_vec(OP_SW)));
    @(posedge clk);
    #1;
    check_val("abort_hold", 32'(obs()), 32'(rst_vec(OP_SW)));
    reset_n = 1'b1;
    #1;
    check_val("abort_fetch", 32'(obs()),
              32'(pk(1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000, 3'b001, 0)));

    for (int n = 0; n < 80; n++) begin
      run_instr(ops[$urandom_range(0, 11)], 3'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
